// File: rtl/carry_look_ahead_pkg.sv
// Shared constants for the 8-bit carry look-ahead adder.
// Width and group size are fixed; the group count is derived from them.
package carry_look_ahead_pkg;
  localparam int WIDTH   = 8;
  localparam int GROUP   = 4;
  localparam int NGROUPS = WIDTH / GROUP;
endpackage

// File: rtl/cla_group4.sv
// One 4-bit look-ahead group: flat sum-of-products carries,
// group propagate/generate for the second-level carry unit.
module cla_group4
  import carry_look_ahead_pkg::*;
(
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             PG,
  output logic             GG
);

  logic [GROUP-1:0] c;

  // Each carry is expanded from ci and the p/g bits only.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c;
  assign PG = &p;
  assign GG = g[3] | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/carry_look_ahead_adder.sv
// 8-bit two-level carry look-ahead adder with registered
// sum/cout and asynchronous active-low reset.
module carry_look_ahead_adder
  import carry_look_ahead_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0]   p;
  logic [WIDTH-1:0]   g;
  logic [NGROUPS-1:0] pg;
  logic [NGROUPS-1:0] gg;
  logic               c4;
  logic               c8;
  logic [WIDTH-1:0]   sum_d;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_d;
  logic               cout_q;

  assign p = a ^ b;
  assign g = a & b;

  cla_group4 u_grp0 (
    .p  (p[GROUP-1:0]),
    .g  (g[GROUP-1:0]),
    .ci (cin),
    .s  (sum_d[GROUP-1:0]),
    .PG (pg[0]),
    .GG (gg[0])
  );

  cla_group4 u_grp1 (
    .p  (p[WIDTH-1:GROUP]),
    .g  (g[WIDTH-1:GROUP]),
    .ci (c4),
    .s  (sum_d[WIDTH-1:GROUP]),
    .PG (pg[1]),
    .GG (gg[1])
  );

  // Second-level carries come straight from cin, never from c4.
  assign c4 = gg[0] | (pg[0] & cin);
  assign c8 = gg[1] | (pg[1] & gg[0])
            | (pg[1] & pg[0] & cin);

  assign cout_d = c8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Directed-vector and random-sweep bench for carry_look_ahead_adder.
// Expected results are hand-computed or taken from a + b + cin.
module tb_carry_look_ahead_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;

  int n_checks;
  int n_fail;

  vec_t vecs [10];

  carry_look_ahead_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] exp);
    n_checks++;
    if ({cout, sum} !== exp) begin
      n_fail++;
      $display("FAIL %s: got cout=%b sum=%h, want cout=%b sum=%h",
               name, cout, sum, exp[8], exp[7:0]);
    end
  endtask

  initial begin
    logic [8:0] prev;
    logic [8:0] exp;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
    vecs[1] = '{8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[8] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[9] = '{8'h3C, 8'h4B, 1'b1, 8'h88, 1'b0};

    // Reset held with nonzero inputs while clk toggles.
    rst_n = 1'b0;
    a     = 8'h5A;
    b     = 8'hC3;
    cin   = 1'b1;
    #1;
    check("reset_async", 9'h000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 9'h000);
    end

    // Release: first edge loads 5A + C3 + 1 = 11E.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_pre_edge", 9'h000);
    @(posedge clk);
    #1;
    check("release_load", 9'h11E);
    prev = 9'h11E;

    // Back-to-back directed vectors, one per cycle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a   = vecs[i].a;
      b   = vecs[i].b;
      cin = vecs[i].cin;
      #1;
      check($sformatf("vec%0d_hold", i), prev);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {vecs[i].cout, vecs[i].sum});
      prev = {vecs[i].cout, vecs[i].sum};
    end

    // Random sweep with an asynchronous reset pulse in the middle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      exp = {1'b0, a} + {1'b0, b} + {8'b0, cin};
      #1;
      check("sweep_hold", prev);
      if (i == 1500) begin
        rst_n = 1'b0;
        #1;
        check("midreset_clear", 9'h000);
        #1;
        rst_n = 1'b1;
        #1;
        check("midreset_release", 9'h000);
      end
      @(posedge clk);
      #1;
      check("sweep", exp);
      prev = exp;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
